// File: rtl/fu_overlay_pkg.sv
// Shared definitions for the FU overlay Xillybus return path.
package fu_overlay_pkg;

  localparam int XIL_W = 32;
  localparam int RES_W = 16;

  localparam logic [RES_W-1:0] PAD_HALF = 16'h0000;

  typedef enum logic {
    LOW      = 1'b0,
    HAVE_LOW = 1'b1
  } pack_state_t;

  function automatic logic [XIL_W-1:0] pack_word(input logic [RES_W-1:0] hi,
                                                 input logic [RES_W-1:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/xil_sync_fifo.sv
// Synchronous FIFO with registered read data, serving a non-FWFT rden/empty reader.
module xil_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [W-1:0] r_rdata;
  logic [AW:0]  w_count;
  logic         w_push_ok;
  logic         w_pop_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign o_full    = (w_count == FULL_CNT);
  assign o_empty   = (w_count == '0);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_rdata   = r_rdata;

  always_ff @(posedge clk) begin
    if (w_push_ok && !i_clr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rdata  <= r_mem[r_rd_ptr[AW-1:0]];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/result_read_packer.sv
// Packs pairs of 16-bit FU results into 32-bit words for the Xillybus read stream.
module result_read_packer
  import fu_overlay_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic               bus_clk,
  input  logic               rst,
  input  logic [RES_W-1:0]   res_data,
  input  logic               res_valid,
  input  logic               res_last,
  output logic               res_ready,
  input  logic               user_r_read_32_open,
  input  logic               user_r_read_32_rden,
  output logic [XIL_W-1:0]   user_r_read_32_data,
  output logic               user_r_read_32_empty,
  output logic [15:0]        words_pushed
);

  pack_state_t      r_state;
  pack_state_t      w_state_nxt;
  logic [RES_W-1:0] r_hold;
  logic [15:0]      r_words_pushed;
  logic             w_clear;
  logic             w_full;
  logic             w_accept;
  logic             w_push;
  logic             w_load_hold;
  logic [XIL_W-1:0] w_word;

  // Closing the device behaves exactly like reset.
  assign w_clear = rst || !user_r_read_32_open;

  // A first half may still enter the hold register while the FIFO is full.
  assign res_ready = user_r_read_32_open && !rst
                     && !((r_state == HAVE_LOW) && w_full)
                     && !((r_state == LOW) && res_last && w_full);

  assign w_accept     = res_valid && res_ready;
  assign words_pushed = r_words_pushed;

  always_ff @(posedge bus_clk) begin
    if (w_clear) begin
      r_state <= LOW;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_load_hold = 1'b0;
    w_word      = pack_word(res_data, r_hold);
    case (r_state)
      LOW: begin
        if (w_accept) begin
          if (res_last) begin
            w_push = 1'b1;
            w_word = pack_word(PAD_HALF, res_data);
          end else begin
            w_load_hold = 1'b1;
            w_state_nxt = HAVE_LOW;
          end
        end
      end
      HAVE_LOW: begin
        if (w_accept) begin
          w_push      = 1'b1;
          w_state_nxt = LOW;
        end
      end
      default: w_state_nxt = LOW;
    endcase
  end

  always_ff @(posedge bus_clk) begin
    if (w_clear) begin
      r_hold         <= '0;
      r_words_pushed <= '0;
    end else begin
      if (w_load_hold) begin
        r_hold <= res_data;
      end
      if (w_push) begin
        r_words_pushed <= r_words_pushed + 16'd1;
      end
    end
  end

  xil_sync_fifo #(
    .DEPTH(DEPTH),
    .W    (XIL_W)
  ) u_fifo (
    .clk    (bus_clk),
    .i_clr  (w_clear),
    .i_push (w_push),
    .i_wdata(w_word),
    .i_pop  (user_r_read_32_rden),
    .o_rdata(user_r_read_32_data),
    .o_full (w_full),
    .o_empty(user_r_read_32_empty)
  );

endmodule

// File: tb/tb_result_read_packer.sv
// Bench for result_read_packer: directed steps then random traffic against a queue-based model.
module tb_result_read_packer;

  localparam int DEPTH = 16;

  logic        bus_clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] res_data = '0;
  logic        res_valid = 1'b0;
  logic        res_last = 1'b0;
  logic        res_ready;
  logic        open = 1'b1;
  logic        rden = 1'b0;
  logic [31:0] rd_data;
  logic        empty;
  logic [15:0] words_pushed;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: queued words, optional pending first half, last read word, push count.
  logic [31:0] mq[$];
  bit          pend = 0;
  logic [15:0] hold = '0;
  logic [31:0] last_rd = '0;
  logic [15:0] cnt = '0;

  always #5 bus_clk = ~bus_clk;

  result_read_packer #(.DEPTH(DEPTH)) dut (
    .bus_clk             (bus_clk),
    .rst                 (rst),
    .res_data            (res_data),
    .res_valid           (res_valid),
    .res_last            (res_last),
    .res_ready           (res_ready),
    .user_r_read_32_open (open),
    .user_r_read_32_rden (rden),
    .user_r_read_32_data (rd_data),
    .user_r_read_32_empty(empty),
    .words_pushed        (words_pushed)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit op, input bit v, input bit l, input bit rd,
                       input logic [15:0] d, output bit acc);
    bit full;
    bit exp_rdy;
    @(negedge bus_clk);
    rst = r; open = op; res_valid = v; res_last = l; rden = rd; res_data = d;
    #1;
    full    = (mq.size() == DEPTH);
    exp_rdy = op && !r && !(pend && full) && !(!pend && l && full);
    chk("res_ready", 32'(res_ready), 32'(exp_rdy));
    chk("empty_pre", 32'(empty), 32'(mq.size() == 0));
    acc = 0;
    if (r || !op) begin
      mq.delete(); pend = 0; hold = '0; last_rd = '0; cnt = '0;
    end else begin
      acc = v && exp_rdy;
      if (rd && mq.size() != 0) last_rd = mq.pop_front();
      if (acc) begin
        if (pend) begin
          mq.push_back({d, hold}); pend = 0; cnt++;
        end else if (l) begin
          mq.push_back({16'h0000, d}); cnt++;
        end else begin
          hold = d; pend = 1;
        end
      end
    end
    @(posedge bus_clk);
    #1;
    chk("rd_data", rd_data, last_rd);
    chk("empty_post", 32'(empty), 32'(mq.size() == 0));
    chk("words_pushed", 32'(words_pushed), 32'(cnt));
  endtask

  initial begin
    bit acc;
    bit pv, pl;
    logic [15:0] pd;
    int rd_bias;

    // Reset held three cycles with the device open.
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0, 16'h0, acc);
    chk("reset_ready", 32'(res_ready), 32'd0);
    cycle(0, 1, 0, 0, 0, 16'h0, acc);
    chk("ready_after_release", 32'(res_ready), 32'd1);

    // Pair 0x0003 / 0x0006 with rden held high.
    cycle(0, 1, 1, 0, 1, 16'h0003, acc);
    cycle(0, 1, 1, 0, 1, 16'h0006, acc);
    chk("pair_empty_falls", 32'(empty), 32'd0);
    cycle(0, 1, 0, 0, 1, 16'h0, acc);
    chk("pair_word", rd_data, 32'h0006_0003);
    chk("pair_count", 32'(words_pushed), 32'd1);

    // Lone last result, then a fresh pair with no stale hold.
    cycle(0, 1, 1, 1, 0, 16'h0009, acc);
    cycle(0, 1, 0, 0, 1, 16'h0, acc);
    chk("last_word", rd_data, 32'h0000_0009);
    cycle(0, 1, 1, 0, 0, 16'h0001, acc);
    cycle(0, 1, 1, 0, 0, 16'h0002, acc);
    cycle(0, 1, 0, 0, 1, 16'h0, acc);
    chk("repack_word", rd_data, 32'h0002_0001);

    // Fill to full, hold a half, stall, pop once, then drain across the wrap.
    for (int i = 0; i < 32; i++) cycle(0, 1, 1, 0, 0, 16'(i), acc);
    chk("full_count", 32'(words_pushed), 32'd19);
    cycle(0, 1, 1, 0, 0, 16'd32, acc);
    chk("half_into_hold", 32'(acc), 32'd1);
    cycle(0, 1, 1, 0, 0, 16'd33, acc);
    chk("stall_when_full", 32'(acc), 32'd0);
    cycle(0, 1, 1, 0, 1, 16'd33, acc);
    chk("pop_word0", rd_data, 32'h0001_0000);
    cycle(0, 1, 1, 0, 0, 16'd33, acc);
    chk("accept_after_pop", 32'(acc), 32'd1);
    for (int i = 0; i < 16; i++) cycle(0, 1, 0, 0, 1, 16'h0, acc);
    chk("drain_last", rd_data, 32'h0021_0020);
    chk("drain_count", 32'(words_pushed), 32'd20);

    // rden while empty must not disturb anything.
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 1, 16'h0, acc);
    chk("empty_rden_hold", rd_data, 32'h0021_0020);

    // Three words plus a pending half, then close for one cycle.
    for (int i = 0; i < 7; i++) cycle(0, 1, 1, 0, 0, 16'(16'h0100 + i), acc);
    cycle(0, 0, 0, 0, 1, 16'h0, acc);
    chk("close_empty", 32'(empty), 32'd1);
    chk("close_data", rd_data, 32'd0);
    chk("close_count", 32'(words_pushed), 32'd0);
    cycle(0, 1, 1, 0, 0, 16'h000A, acc);
    cycle(0, 1, 1, 0, 0, 16'h000B, acc);
    cycle(0, 1, 0, 0, 1, 16'h0, acc);
    chk("after_close_word", rd_data, 32'h000B_000A);

    // Random traffic; producer holds a result until it is accepted.
    pv = 0; pl = 0; pd = '0; rd_bias = 2;
    for (int i = 0; i < 600; i++) begin
      bit r, op;
      if (i % 60 == 0) rd_bias = $urandom_range(0, 4);
      if (!pv) begin
        pv = ($urandom_range(0, 3) != 0);
        pl = pv && ($urandom_range(0, 5) == 0);
        pd = 16'($urandom);
      end
      r  = ($urandom_range(0, 199) == 0);
      op = ($urandom_range(0, 119) != 0);
      cycle(r, op, pv, pl, ($urandom_range(0, 3) < rd_bias), pd, acc);
      if (acc) pv = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
